// File: rtl/raybox_pov_pkg.sv
// raybox_pov_pkg
//   Shared definitions for the raybox POV controller: default vector width,
//   movement step shift, reset point-of-view constants (Q6.10) and the
//   commit FSM state encoding.
package raybox_pov_pkg;

  localparam int POV_VEC_W      = 16;
  localparam int POV_STEP_SHIFT = 4;
  localparam int POV_N_COMP     = 6;  // playerX/Y, facingX/Y, vplaneX/Y

  localparam logic [15:0] POV_PLAYER_X0 = 16'h0C00;  // 3.0
  localparam logic [15:0] POV_PLAYER_Y0 = 16'h0C00;  // 3.0
  localparam logic [15:0] POV_FACING_X0 = 16'h0400;  // 1.0
  localparam logic [15:0] POV_FACING_Y0 = 16'h0000;  // 0.0
  localparam logic [15:0] POV_VPLANE_X0 = 16'h0000;  // 0.0
  localparam logic [15:0] POV_VPLANE_Y0 = 16'h0200;  // 0.5

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } pov_state_e;

endpackage

// File: rtl/raybox_spi_rx.sv
// raybox_spi_rx
//   Receives one POV frame from an SPI host (mode 0, MSB first). The raw
//   pins are brought into clk through 2-FF synchronisers; mosi is sampled on
//   the synchronised sclk rising edge while ss_n is low. The ss_n rising edge
//   closes the frame: exactly FRAME_BITS bits gives frame_valid, anything
//   else gives frame_err.
// Ports
//   clk, reset_n          clock, async active-low reset
//   i_sclk/i_mosi/i_ss_n  raw SPI pins (asynchronous to clk)
//   frame_valid           1-cycle pulse, payload holds a complete frame
//   frame_err             1-cycle pulse, frame discarded (bad bit count)
//   payload               shifted frame, first received bit at the MSB
module raybox_spi_rx
  import raybox_pov_pkg::*;
#(
  parameter int VEC_W = POV_VEC_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_sclk,
  input  logic                        i_mosi,
  input  logic                        i_ss_n,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic [POV_N_COMP*VEC_W-1:0] payload
);

  localparam int FRAME_BITS = POV_N_COMP * VEC_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic [1:0]            sclk_sync_q, sclk_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [1:0]            ss_sync_q,   ss_sync_d;
  logic                  sclk_prev_q, sclk_prev_d;
  logic                  ss_prev_q,   ss_prev_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [FRAME_BITS-1:0] shift_q,     shift_d;
  logic                  valid_q,     valid_d;
  logic                  err_q,       err_d;

  logic sclk_rise, ss_fall, ss_rise;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], i_sclk};
    mosi_sync_d = {mosi_sync_q[0], i_mosi};
    ss_sync_d   = {ss_sync_q[0], i_ss_n};
    sclk_prev_d = sclk_sync_q[1];
    ss_prev_d   = ss_sync_q[1];

    sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    ss_fall   = ~ss_sync_q[1] & ss_prev_q;
    ss_rise   = ss_sync_q[1] & ~ss_prev_q;

    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (ss_fall) begin
      cnt_d = '0;
    end else if (!ss_sync_q[1] && sclk_rise) begin
      // Overlong frames stop shifting but keep counting one past full so
      // the closing edge still sees a bad count.
      if (cnt_q < CNT_FULL) shift_d = {shift_q[FRAME_BITS-2:0], mosi_sync_q[1]};
      if (cnt_q < CNT_SAT)  cnt_d   = cnt_q + 1'b1;
    end

    if (ss_rise) begin
      if (cnt_q == CNT_FULL) valid_d = 1'b1;
      else                   err_d   = 1'b1;
    end
  end

  // ss_n synchronisers reset to the idle-high level so releasing reset with
  // the bus idle does not look like a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign payload     = shift_q;

endmodule

// File: rtl/raybox_pov_ctrl.sv
// raybox_pov_ctrl
//   Owns the committed point-of-view vectors (player, facing, vplane) and
//   only changes them on a frame boundary. A complete SPI upload waits in a
//   shadow register; on frame_tick it wins over the movement buttons.
//   Otherwise the synchronised buttons move the player along facing (F/B)
//   and vplane (L/R) by vector >>> STEP_SHIFT, wrapping in VEC_W bits.
// Ports
//   clk, reset_n                 clock, async active-low reset
//   i_sclk/i_mosi/i_ss_n         raw SPI from the host
//   moveL/moveR/moveF/moveB      raw movement request levels
//   frame_tick                   1-cycle pulse at start of vblank
//   new_player*/facing*/vplane*  committed POV
//   write_new_position           1-cycle strobe while new_* show a new value
//   spi_pending                  uploaded frame waiting for commit
//   spi_err                      1-cycle pulse, SPI frame discarded
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for frame_tick
//   ST_COMMIT | new_* just updated (strobe high if anything changed); ticks ignored
module raybox_pov_ctrl
  import raybox_pov_pkg::*;
#(
  parameter int               VEC_W      = POV_VEC_W,
  parameter int               STEP_SHIFT = POV_STEP_SHIFT,
  parameter logic [VEC_W-1:0] PLAYER_X0  = POV_PLAYER_X0,
  parameter logic [VEC_W-1:0] PLAYER_Y0  = POV_PLAYER_Y0,
  parameter logic [VEC_W-1:0] FACING_X0  = POV_FACING_X0,
  parameter logic [VEC_W-1:0] FACING_Y0  = POV_FACING_Y0,
  parameter logic [VEC_W-1:0] VPLANE_X0  = POV_VPLANE_X0,
  parameter logic [VEC_W-1:0] VPLANE_Y0  = POV_VPLANE_Y0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss_n,
  input  logic             moveL,
  input  logic             moveR,
  input  logic             moveF,
  input  logic             moveB,
  input  logic             frame_tick,
  output logic [VEC_W-1:0] new_playerX,
  output logic [VEC_W-1:0] new_playerY,
  output logic [VEC_W-1:0] new_facingX,
  output logic [VEC_W-1:0] new_facingY,
  output logic [VEC_W-1:0] new_vplaneX,
  output logic [VEC_W-1:0] new_vplaneY,
  output logic             write_new_position,
  output logic             spi_pending,
  output logic             spi_err
);

  localparam int FRAME_BITS = POV_N_COMP * VEC_W;

  logic                  rx_valid, rx_err;
  logic [FRAME_BITS-1:0] rx_payload;

  raybox_spi_rx #(.VEC_W(VEC_W)) u_spi_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_sclk     (i_sclk),
    .i_mosi     (i_mosi),
    .i_ss_n     (i_ss_n),
    .frame_valid(rx_valid),
    .frame_err  (rx_err),
    .payload    (rx_payload)
  );

  pov_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic                    strobe_q, strobe_d;
  logic [3:0]              btn_meta_q, btn_q;  // {L, R, F, B}
  logic signed [VEC_W-1:0] px_q, px_d, py_q, py_d;
  logic signed [VEC_W-1:0] fx_q, fx_d, fy_q, fy_d;
  logic signed [VEC_W-1:0] vx_q, vx_d, vy_q, vy_d;

  logic                    btn_l, btn_r, btn_f, btn_b;
  logic                    fwd_en, side_en;
  logic signed [VEC_W-1:0] stp_fx, stp_fy, stp_vx, stp_vy;
  logic signed [VEC_W-1:0] dfx, dfy, dsx, dsy;

  always_comb begin
    {btn_l, btn_r, btn_f, btn_b} = btn_q;
    // Opposing buttons cancel each other on their own axis only.
    fwd_en  = btn_f ^ btn_b;
    side_en = btn_l ^ btn_r;

    stp_fx = fx_q >>> STEP_SHIFT;
    stp_fy = fy_q >>> STEP_SHIFT;
    stp_vx = vx_q >>> STEP_SHIFT;
    stp_vy = vy_q >>> STEP_SHIFT;

    dfx = !fwd_en  ? '0 : (btn_b ? -stp_fx : stp_fx);
    dfy = !fwd_en  ? '0 : (btn_b ? -stp_fy : stp_fy);
    dsx = !side_en ? '0 : (btn_l ? -stp_vx : stp_vx);
    dsy = !side_en ? '0 : (btn_l ? -stp_vy : stp_vy);

    state_d   = state_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    strobe_d  = 1'b0;
    px_d = px_q;
    py_d = py_q;
    fx_d = fx_q;
    fy_d = fy_q;
    vx_d = vx_q;
    vy_d = vy_q;

    // The update is registered on the edge that enters ST_COMMIT, so new_*
    // and the strobe are both visible during the COMMIT cycle.
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_COMMIT;
          if (pending_q) begin
            px_d = shadow_q[5*VEC_W +: VEC_W];
            py_d = shadow_q[4*VEC_W +: VEC_W];
            fx_d = shadow_q[3*VEC_W +: VEC_W];
            fy_d = shadow_q[2*VEC_W +: VEC_W];
            vx_d = shadow_q[1*VEC_W +: VEC_W];
            vy_d = shadow_q[0*VEC_W +: VEC_W];
            pending_d = 1'b0;
            strobe_d  = 1'b1;
          end else if (fwd_en || side_en) begin
            px_d = px_q + dfx + dsx;
            py_d = py_q + dfy + dsy;
            strobe_d = 1'b1;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A frame completing alongside a commit survives as pending for the
    // next tick.
    if (rx_valid) begin
      shadow_d  = rx_payload;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      strobe_q   <= 1'b0;
      btn_meta_q <= '0;
      btn_q      <= '0;
      px_q       <= PLAYER_X0;
      py_q       <= PLAYER_Y0;
      fx_q       <= FACING_X0;
      fy_q       <= FACING_Y0;
      vx_q       <= VPLANE_X0;
      vy_q       <= VPLANE_Y0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      strobe_q   <= strobe_d;
      btn_meta_q <= {moveL, moveR, moveF, moveB};
      btn_q      <= btn_meta_q;
      px_q       <= px_d;
      py_q       <= py_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
    end
  end

  assign new_playerX        = px_q;
  assign new_playerY        = py_q;
  assign new_facingX        = fx_q;
  assign new_facingY        = fy_q;
  assign new_vplaneX        = vx_q;
  assign new_vplaneY        = vy_q;
  assign write_new_position = strobe_q;
  assign spi_pending        = pending_q;
  assign spi_err            = rx_err;

endmodule

// File: tb/tb_raybox_pov_ctrl.sv
// tb_raybox_pov_ctrl
//   Self-checking bench for raybox_pov_ctrl: a button table walked from reset,
//   hand sequences for SPI uploads / errors / resets, then random traffic
//   compared against a component-array reference model.
module tb_raybox_pov_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_sclk, i_mosi, i_ss_n;
  logic        moveL, moveR, moveF, moveB;
  logic        frame_tick;
  logic [15:0] new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY;
  logic        write_new_position, spi_pending, spi_err;

  raybox_pov_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_sclk            (i_sclk),
    .i_mosi            (i_mosi),
    .i_ss_n            (i_ss_n),
    .moveL             (moveL),
    .moveR             (moveR),
    .moveF             (moveF),
    .moveB             (moveB),
    .frame_tick        (frame_tick),
    .new_playerX       (new_playerX),
    .new_playerY       (new_playerY),
    .new_facingX       (new_facingX),
    .new_facingY       (new_facingY),
    .new_vplaneX       (new_vplaneX),
    .new_vplaneY       (new_vplaneY),
    .write_new_position(write_new_position),
    .spi_pending       (spi_pending),
    .spi_err           (spi_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int strobe_cnt = 0;

  always @(posedge clk) begin
    if (spi_err === 1'b1)            err_pulses <= err_pulses + 1;
    if (write_new_position === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Reference model: index 0..5 = playerX, playerY, facingX, facingY, vplaneX, vplaneY
  logic [15:0] m_pov[6];
  logic [15:0] m_shadow[6];
  bit          m_pending;

  localparam logic [95:0] RESET_POV = {16'h0C00, 16'h0C00, 16'h0400, 16'h0000, 16'h0000, 16'h0200};

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_pov[i] = RESET_POV[(5-i)*16 +: 16];
    m_pending = 0;
  endtask

  // floor(v / 16) of the signed value
  function automatic int step_of(logic [15:0] v);
    int s;
    s = int'($signed(v));
    return (s >= 0) ? s / 16 : -((-s + 15) / 16);
  endfunction

  task automatic model_tick(input bit l, input bit r, input bit f, input bit b, output bit es);
    int fwd, side;
    if (m_pending) begin
      for (int i = 0; i < 6; i++) m_pov[i] = m_shadow[i];
      m_pending = 0;
      es = 1;
    end else begin
      fwd  = int'(f) - int'(b);
      side = int'(r) - int'(l);
      if (fwd == 0 && side == 0) es = 0;
      else begin
        m_pov[0] = 16'(int'(m_pov[0]) + fwd * step_of(m_pov[2]) + side * step_of(m_pov[4]));
        m_pov[1] = 16'(int'(m_pov[1]) + fwd * step_of(m_pov[3]) + side * step_of(m_pov[5]));
        es = 1;
      end
    end
  endtask

  function automatic logic [95:0] model_vec();
    logic [95:0] v;
    for (int i = 0; i < 6; i++) v[(5-i)*16 +: 16] = m_pov[i];
    return v;
  endfunction

  function automatic logic [95:0] dut_vec();
    return {new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit f, input bit b);
    @(posedge clk); #1;
    moveL = l; moveR = r; moveF = f; moveB = b;
    repeat (4) @(posedge clk);
  endtask

  // Pulses frame_tick for one cycle; returns at the negedge of the COMMIT cycle.
  task automatic do_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_check(input string name);
    bit es;
    model_tick(moveL, moveR, moveF, moveB, es);
    do_tick();
    check({name, " strobe"}, 96'(write_new_position), 96'(es));
    check({name, " pov"}, dut_vec(), model_vec());
    check({name, " pending"}, 96'(spi_pending), 96'(m_pending));
    @(negedge clk);
    check({name, " strobe width"}, 96'(write_new_position), 96'd0);
  endtask

  task automatic spi_begin();
    @(posedge clk); #1 i_ss_n = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Sends bits [from, to) of a frame; bits past 95 are random filler.
  task automatic spi_bits(input logic [95:0] data, input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk); #1 i_mosi = (i < 96) ? data[95-i] : 1'($urandom);
      repeat (3) @(posedge clk); #1 i_sclk = 1'b1;
      repeat (3) @(posedge clk); #1 i_sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (3) @(posedge clk); #1 i_ss_n = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic spi_frame(input string name, input logic [95:0] data, input int n);
    int e0;
    e0 = err_pulses;
    spi_begin();
    spi_bits(data, 0, n);
    spi_end();
    if (n == 96) begin
      for (int i = 0; i < 6; i++) m_shadow[i] = data[(5-i)*16 +: 16];
      m_pending = 1;
    end
    @(negedge clk);
    check({name, " spi_err pulses"}, 96'(err_pulses - e0), 96'((n == 96) ? 0 : 1));
    check({name, " pending"}, 96'(spi_pending), 96'(m_pending));
  endtask

  typedef struct {
    bit l, r, f, b;
    int dx, dy;
    bit st;
  } vec_t;

  vec_t        tbl[10];
  logic [15:0] exp_px, exp_py;
  logic [95:0] frame;
  int          s0;
  int          nb;
  int          nsel[7] = '{96, 96, 96, 95, 97, 0, 100};

  initial begin
    // Button table walked from the reset POV: F/B step 0x40 in X, L/R step 0x20 in Y.
    tbl[0] = '{0, 0, 0, 0,   0,   0, 0};
    tbl[1] = '{0, 0, 1, 0,  64,   0, 1};
    tbl[2] = '{0, 1, 0, 0,   0,  32, 1};
    tbl[3] = '{1, 0, 0, 0,   0, -32, 1};
    tbl[4] = '{1, 0, 1, 1,   0, -32, 1};
    tbl[5] = '{0, 0, 0, 1, -64,   0, 1};
    tbl[6] = '{0, 0, 1, 1,   0,   0, 0};
    tbl[7] = '{0, 1, 1, 0,  64,  32, 1};
    tbl[8] = '{1, 1, 0, 0,   0,   0, 0};
    tbl[9] = '{1, 1, 1, 1,   0,   0, 0};

    reset_n = 1'b0;
    i_sclk = 1'b0; i_mosi = 1'b0; i_ss_n = 1'b1;
    moveL = 1'b0; moveR = 1'b0; moveF = 1'b0; moveB = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    check("reset pov", dut_vec(), RESET_POV);
    check("reset strobe", 96'(write_new_position), 96'd0);
    check("reset pending", 96'(spi_pending), 96'd0);
    check("reset spi_err", 96'(spi_err), 96'd0);

    // Idle frames never strobe.
    s0 = strobe_cnt;
    for (int i = 0; i < 3; i++) tick_check("idle tick");
    check("idle strobe count", 96'(strobe_cnt - s0), 96'd0);

    // Table walk
    exp_px = 16'h0C00;
    exp_py = 16'h0C00;
    for (int i = 0; i < 10; i++) begin
      bit es;
      set_buttons(tbl[i].l, tbl[i].r, tbl[i].f, tbl[i].b);
      model_tick(tbl[i].l, tbl[i].r, tbl[i].f, tbl[i].b, es);
      exp_px = 16'(int'(exp_px) + tbl[i].dx);
      exp_py = 16'(int'(exp_py) + tbl[i].dy);
      do_tick();
      check($sformatf("table %0d strobe", i), 96'(write_new_position), 96'(tbl[i].st));
      check($sformatf("table %0d player", i), {new_playerX, new_playerY}, {exp_px, exp_py});
      check($sformatf("table %0d dirs", i), {new_facingX, new_facingY, new_vplaneX, new_vplaneY},
            RESET_POV[63:0]);
    end

    // Held tick across COMMIT applies once.
    set_buttons(0, 0, 1, 0);
    begin
      bit es;
      model_tick(0, 0, 1, 0, es);
    end
    s0 = strobe_cnt;
    @(posedge clk); #1 frame_tick = 1'b1;
    repeat (2) @(posedge clk); #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("double tick strobes", 96'(strobe_cnt - s0), 96'd1);
    check("double tick pov", dut_vec(), model_vec());

    // Upload wins over a held moveF.
    set_buttons(0, 0, 0, 0);
    spi_frame("upload", {16'h0100, 16'h0200, 16'hFC00, 16'h0000, 16'h0000, 16'hFE00}, 96);
    set_buttons(0, 0, 1, 0);
    tick_check("upload commit");
    check("upload values", dut_vec(), {16'h0100, 16'h0200, 16'hFC00, 16'h0000, 16'h0000, 16'hFE00});

    // Bad bit counts are discarded.
    set_buttons(0, 0, 0, 0);
    spi_frame("95 bits", {$urandom, $urandom, $urandom}, 95);
    tick_check("after 95 bits");
    spi_frame("97 bits", {$urandom, $urandom, $urandom}, 97);
    tick_check("after 97 bits");

    // Tick in the middle of a frame: buttons apply, the frame still lands.
    frame = {$urandom, $urandom, $urandom};
    spi_begin();
    spi_bits(frame, 0, 48);
    set_buttons(0, 1, 1, 0);
    tick_check("mid-frame tick");
    set_buttons(0, 0, 0, 0);
    spi_bits(frame, 48, 96);
    spi_end();
    for (int i = 0; i < 6; i++) m_shadow[i] = frame[(5-i)*16 +: 16];
    m_pending = 1;
    @(negedge clk);
    check("split frame pending", 96'(spi_pending), 96'd1);
    tick_check("split frame commit");

    // Reset in the middle of a frame.
    spi_begin();
    spi_bits({$urandom, $urandom, $urandom}, 0, 40);
    @(posedge clk); #1 reset_n = 1'b0;
    i_ss_n = 1'b1; i_sclk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    check("mid-frame reset pov", dut_vec(), RESET_POV);
    check("mid-frame reset pending", 96'(spi_pending), 96'd0);
    repeat (8) @(posedge clk);
    spi_frame("post-reset frame", {$urandom, $urandom, $urandom}, 96);
    tick_check("post-reset commit");

    // Random traffic against the model.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        nb = nsel[$urandom_range(0, 6)];
        spi_frame($sformatf("rand %0d spi n=%0d", it, nb), {$urandom, $urandom, $urandom}, nb);
      end else begin
        set_buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        tick_check($sformatf("rand %0d tick", it));
      end
    end
    set_buttons(0, 0, 0, 0);
    tick_check("final tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
